// File: rtl/servo_pwm_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_array_pkg
// Description : Default timing constants and width helpers for the servo array
// Revision    : 1.0 - initial release
// ============================================================================
package servo_pwm_array_pkg;

    localparam int c_TICK_DIV    = 500;
    localparam int c_FRAME_TICKS = 2000;
    localparam int c_MIN_TICKS   = 100;
    localparam int c_MAX_TICKS   = 200;

    // One spare code above NCH-1 so out-of-range indices stay representable
    // even when NCH is a power of two.
    function automatic int f_ch_w(input int nch);
        return $clog2(nch + 1);
    endfunction

    function automatic int f_frame_w(input int frame_ticks);
        return $clog2(frame_ticks + 1);
    endfunction

    function automatic int f_cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_array_if.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_array_if
// Description : Position write strobe port of the servo PWM array
// Revision    : 1.0 - initial release
// ============================================================================
interface servo_pwm_array_if #(
    parameter int NCH   = 4,
    parameter int POS_W = 8
);
    localparam int CH_W = servo_pwm_array_pkg::f_ch_w(NCH);

    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [POS_W-1:0]  wr_pos;

    modport master (output wr_en, output wr_ch, output wr_pos);
    modport slave  (input  wr_en, input  wr_ch, input  wr_pos);
endinterface
`default_nettype wire

// File: rtl/servo_pwm_array_channel.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_array_channel
// Description : One servo channel: target register, slewed width, PWM compare
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_array_channel #(
    parameter int POS_W     = 8,
    parameter int FW        = 11,
    parameter int MIN_TICKS = 100,
    parameter int MAX_TICKS = 200,
    parameter int SLEW      = 0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_en,
    input  wire logic             i_fb,
    input  wire logic [FW-1:0]    i_frame_cnt,
    input  wire logic             i_wr,
    input  wire logic [POS_W-1:0] i_pos,
    output logic                  o_pwm,
    output logic                  o_busy
);
    localparam int W  = FW + 1;
    localparam int SW = ((POS_W > W) ? POS_W : W) + 1;

    logic [POS_W-1:0] r_pos;
    logic [W-1:0]     r_cur;
    logic [SW-1:0]    w_sum;
    logic [W-1:0]     w_tgt;
    logic [W-1:0]     w_diff;
    logic [W-1:0]     w_step;
    logic [W-1:0]     w_next;

    // Sum is formed wide enough that the clamp sees the true value.
    assign w_sum = SW'(MIN_TICKS) + SW'(r_pos);

    always_comb begin
        w_tgt = '0;
        if (r_pos != '0) begin
            if (w_sum > SW'(MAX_TICKS)) w_tgt = W'(MAX_TICKS);
            else                        w_tgt = w_sum[W-1:0];
        end
    end

    always_comb begin
        w_diff = (w_tgt > r_cur) ? (w_tgt - r_cur) : (r_cur - w_tgt);
        w_step = (int'(w_diff) <= SLEW) ? w_diff : W'(SLEW);
        if (w_tgt == '0 || r_cur == '0 || SLEW == 0) w_next = w_tgt;
        else if (w_tgt > r_cur)                      w_next = r_cur + w_step;
        else                                         w_next = r_cur - w_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos  <= '0;
            r_cur  <= '0;
            o_pwm  <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            if (i_wr) r_pos <= i_pos;
            if (i_fb) r_cur <= w_next;
            o_pwm  <= i_en && ({1'b0, i_frame_cnt} < r_cur);
            o_busy <= (r_cur != w_tgt);
        end
    end
endmodule
`default_nettype wire

// File: rtl/servo_pwm_array.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_array
// Description : NCH-channel hobby-servo PWM generator with frame-aligned update
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_array
    import servo_pwm_array_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int POS_W       = 8,
    parameter int TICK_DIV    = c_TICK_DIV,
    parameter int FRAME_TICKS = c_FRAME_TICKS,
    parameter int MIN_TICKS   = c_MIN_TICKS,
    parameter int MAX_TICKS   = c_MAX_TICKS,
    parameter int SLEW        = 0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_en,
    servo_pwm_array_if.slave   bus,
    output logic [NCH-1:0]     o_sg90,
    output logic               o_frame_stb,
    output logic [NCH-1:0]     o_busy
);
    localparam int PW   = f_cnt_w(TICK_DIV);
    localparam int FW   = f_frame_w(FRAME_TICKS);
    localparam int CH_W = f_ch_w(NCH);

    logic [PW-1:0] r_psc;
    logic [FW-1:0] r_fcnt;
    logic          w_tick;
    logic          w_fb;

    assign w_tick = i_en && (r_psc == PW'(TICK_DIV - 1));
    assign w_fb   = w_tick && (r_fcnt == FW'(FRAME_TICKS - 1));

    // Disabled state parks the counters so the first boundary lands
    // exactly TICK_DIV cycles after enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc       <= '0;
            r_fcnt      <= FW'(FRAME_TICKS - 1);
            o_frame_stb <= 1'b0;
        end else begin
            o_frame_stb <= w_fb;
            if (!i_en) begin
                r_psc  <= '0;
                r_fcnt <= FW'(FRAME_TICKS - 1);
            end else if (w_tick) begin
                r_psc  <= '0;
                r_fcnt <= (r_fcnt == FW'(FRAME_TICKS - 1)) ? '0 : r_fcnt + FW'(1);
            end else begin
                r_psc  <= r_psc + PW'(1);
            end
        end
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic w_wr;
            assign w_wr = bus.wr_en && (bus.wr_ch == CH_W'(i));

            servo_pwm_array_channel #(
                .POS_W     (POS_W),
                .FW        (FW),
                .MIN_TICKS (MIN_TICKS),
                .MAX_TICKS (MAX_TICKS),
                .SLEW      (SLEW)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_en        (i_en),
                .i_fb        (w_fb),
                .i_frame_cnt (r_fcnt),
                .i_wr        (w_wr),
                .i_pos       (bus.wr_pos),
                .o_pwm       (o_sg90[i]),
                .o_busy      (o_busy[i])
            );
        end
    endgenerate
endmodule
`default_nettype wire
